// File: rtl/alu_mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   - op-code encodings (3-bit, MUL..REMU)
//   - FSM state encoding
//   - op decode helper returning the signedness / high-half / remainder flags
package alu_mdu_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic is_div;
      logic is_rem;
      logic is_high;
      logic s1_signed;
      logic s2_signed;
   } op_dec_t;

   function automatic op_dec_t decode_op(input logic [2:0] op);
      op_dec_t d;
      d.is_div    = op[2];
      d.is_rem    = op[2] & op[1];
      d.is_high   = !op[2] && (op != OP_MUL);
      d.s1_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      d.s2_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      return d;
   endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle of the multiply/divide unit.
//   master: drives start_i, op_i, src1_i, src2_i, flush_i; observes busy_o, res_valid_o, res_o
//   slave : the unit itself
interface alu_mdu_if #(
   parameter int XLEN     = 32,
   parameter int OP_WIDTH = 3
);
   logic                start_i;
   logic [OP_WIDTH-1:0] op_i;
   logic [XLEN-1:0]     src1_i;
   logic [XLEN-1:0]     src2_i;
   logic                flush_i;
   logic                busy_o;
   logic                res_valid_o;
   logic [XLEN-1:0]     res_o;

   modport master (
      output start_i, op_i, src1_i, src2_i, flush_i,
      input  busy_o, res_valid_o, res_o
   );

   modport slave (
      input  start_i, op_i, src1_i, src2_i, flush_i,
      output busy_o, res_valid_o, res_o
   );
endinterface

// File: rtl/alu_mdu_div.sv
// Iterative restoring radix-2 divider over unsigned magnitudes.
//   start_i            : load dividend/divisor, begin XLEN iterations
//   abort_i            : drop the operation in flight
//   done_o             : high during the last iteration
//   quot_o / rem_o     : result of the current iteration; final while done_o is high
module alu_mdu_div #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_i,
   input  logic            abort_i,
   input  logic [XLEN-1:0] dividend_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic            done_o,
   output logic [XLEN-1:0] quot_o,
   output logic [XLEN-1:0] rem_o
);
   localparam int CW = $clog2(XLEN + 1);

   logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q;
   logic [CW-1:0]   cnt_q;
   logic            active_q;
   logic [XLEN:0]   partial, diff;

   // quo_q starts as the dividend and shifts quotient bits in from the right.
   always_comb begin
      partial = {rem_q, quo_q[XLEN-1]};
      diff    = partial - {1'b0, dvs_q};
      if (diff[XLEN]) begin
         rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
         quo_d = {quo_q[XLEN-2:0], 1'b0};
      end else begin
         rem_d = diff[XLEN-1:0];
         quo_d = {quo_q[XLEN-2:0], 1'b1};
      end
   end

   // Results are taken combinationally on the last iteration so the caller
   // can finish on the same edge that produces the final quotient bit.
   assign done_o = active_q && (cnt_q == CW'(1));
   assign quot_o = quo_d;
   assign rem_o  = rem_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q    <= '0;
         quo_q    <= '0;
         dvs_q    <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else if (start_i) begin
         rem_q    <= '0;
         quo_q    <= dividend_i;
         dvs_q    <= divisor_i;
         cnt_q    <= CW'(XLEN);
         active_q <= 1'b1;
      end else if (abort_i) begin
         active_q <= 1'b0;
      end else if (active_q) begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         cnt_q <= cnt_q - CW'(1);
         if (cnt_q == CW'(1)) active_q <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_mdu.sv
// Multiply/divide unit: RV-style MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
//   clk, rst_n : clock, async active-low reset
//   bus        : request (start_i/op_i/src1_i/src2_i/flush_i) and
//                response (busy_o/res_valid_o/res_o)
//
//   state  | meaning
//   IDLE   | waiting for start_i; accepts one op
//   MUL    | product of registered magnitudes, sign-fixed and registered
//   DIV    | divider iterating, one quotient bit per cycle
//   DONE   | res_valid_o high for one cycle, res_o holds the result
module alu_mdu
   import alu_mdu_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int OP_WIDTH = 3
) (
   input logic       clk,
   input logic       rst_n,
   alu_mdu_if.slave  bus
);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state_q, state_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   src1_q, src1_d, src2_q, src2_d, res_q, res_d;
   logic              res_valid_q, res_valid_d;

   op_dec_t           dec_in, dec_q;
   logic              in_op_ok, in_neg1, in_neg2, neg1_q, neg2_q;
   logic [XLEN-1:0]   in_mag1, in_mag2, mag1_q, mag2_q;
   logic [2*XLEN-1:0] prod_mag, prod;

   logic              div_start, div_abort, div_done;
   logic [XLEN-1:0]   div_quot, div_rem;

   assign dec_in   = decode_op(bus.op_i[2:0]);
   assign in_op_ok = (bus.op_i >> 3) == '0;
   assign in_neg1  = dec_in.s1_signed & bus.src1_i[XLEN-1];
   assign in_neg2  = dec_in.s2_signed & bus.src2_i[XLEN-1];
   assign in_mag1  = in_neg1 ? -bus.src1_i : bus.src1_i;
   assign in_mag2  = in_neg2 ? -bus.src2_i : bus.src2_i;

   assign dec_q    = decode_op(op_q);
   assign neg1_q   = dec_q.s1_signed & src1_q[XLEN-1];
   assign neg2_q   = dec_q.s2_signed & src2_q[XLEN-1];
   assign mag1_q   = neg1_q ? -src1_q : src1_q;
   assign mag2_q   = neg2_q ? -src2_q : src2_q;
   assign prod_mag = {{XLEN{1'b0}}, mag1_q} * {{XLEN{1'b0}}, mag2_q};
   assign prod     = (neg1_q ^ neg2_q) ? -prod_mag : prod_mag;

   alu_mdu_div #(.XLEN(XLEN)) u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .abort_i    (div_abort),
      .dividend_i (in_mag1),
      .divisor_i  (in_mag2),
      .done_o     (div_done),
      .quot_o     (div_quot),
      .rem_o      (div_rem)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      src1_d      = src1_q;
      src2_d      = src2_q;
      res_d       = res_q;
      res_valid_d = 1'b0;
      div_start   = 1'b0;
      div_abort   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start_i && !bus.flush_i) begin
               op_d   = bus.op_i[2:0];
               src1_d = bus.src1_i;
               src2_d = bus.src2_i;
               if (!in_op_ok) begin
                  state_d     = S_DONE;
                  res_valid_d = 1'b1;
                  res_d       = '0;
               end else if (!dec_in.is_div) begin
                  state_d = S_MUL;
               end else if (bus.src2_i == '0) begin
                  state_d     = S_DONE;
                  res_valid_d = 1'b1;
                  res_d       = dec_in.is_rem ? bus.src1_i : '1;
               end else if (dec_in.s1_signed && bus.src1_i == MIN_NEG && bus.src2_i == '1) begin
                  state_d     = S_DONE;
                  res_valid_d = 1'b1;
                  res_d       = dec_in.is_rem ? '0 : MIN_NEG;
               end else begin
                  state_d   = S_DIV;
                  div_start = 1'b1;
               end
            end
         end
         S_MUL: begin
            if (bus.flush_i) begin
               state_d = S_IDLE;
            end else begin
               state_d     = S_DONE;
               res_valid_d = 1'b1;
               res_d       = dec_q.is_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
            end
         end
         S_DIV: begin
            if (bus.flush_i) begin
               state_d   = S_IDLE;
               div_abort = 1'b1;
            end else if (div_done) begin
               state_d     = S_DONE;
               res_valid_d = 1'b1;
               // Remainder follows the dividend's sign; quotient is negative iff signs differ.
               if (dec_q.is_rem) res_d = neg1_q ? -div_rem : div_rem;
               else              res_d = (neg1_q ^ neg2_q) ? -div_quot : div_quot;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         src1_q      <= '0;
         src2_q      <= '0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         src1_q      <= src1_d;
         src2_q      <= src2_d;
         res_q       <= res_d;
         res_valid_q <= res_valid_d;
      end
   end

   assign bus.busy_o      = (state_q != S_IDLE);
   assign bus.res_valid_o = res_valid_q;
   assign bus.res_o       = res_q;
endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (XLEN=32): directed corner vectors,
// flush and reset scenarios, then randomized ops against a reference model
// built on plain 64-bit signed/unsigned arithmetic.
module tb_alu_mdu;
   import alu_mdu_pkg::*;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] last_res = '0;

   alu_mdu_if #(.XLEN(32), .OP_WIDTH(3)) bus ();

   alu_mdu #(.XLEN(32), .OP_WIDTH(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      case (op)
         OP_MUL:    begin p = 64'(ua * ub); return p[31:0];  end
         OP_MULH:   begin p = 64'(sa * sb); return p[63:32]; end
         OP_MULHSU: begin p = 64'(sa * ub); return p[63:32]; end
         OP_MULHU:  begin p = 64'(ua * ub); return p[63:32]; end
         OP_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'($signed(a) / $signed(b));
         end
         OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'($signed(a) % $signed(b));
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op < OP_DIV) return 2;
      if (b == 0) return 1;
      if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   // Issues one op (caller sits away from a rising edge, unit in IDLE) and
   // follows it to completion while scrambling the inputs and pulsing start_i.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input int exp_lat, input string tag);
      int k;
      bus.start_i = 1'b1;
      bus.op_i    = op;
      bus.src1_i  = a;
      bus.src2_i  = b;
      @(posedge clk); #1;
      bus.op_i   = 3'($urandom);
      bus.src1_i = 32'($urandom);
      bus.src2_i = 32'($urandom);
      bus.start_i = 1'b0;
      check({tag, ":busy"}, 32'(bus.busy_o), 32'h1);
      k = 1;
      while (!bus.res_valid_o && k < 40) begin
         bus.start_i = 1'($urandom_range(0, 1));
         bus.src1_i  = 32'($urandom);
         @(posedge clk); #1;
         k++;
      end
      bus.start_i = 1'b0;
      check({tag, ":latency"}, 32'(k), 32'(exp_lat));
      check({tag, ":result"}, bus.res_o, exp_r);
      @(posedge clk); #1;
      check({tag, ":valid_drop"}, 32'(bus.res_valid_o), 32'h0);
      check({tag, ":idle"}, 32'(bus.busy_o), 32'h0);
      check({tag, ":hold"}, bus.res_o, exp_r);
      last_res = exp_r;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;

      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.op_i    = '0;
      bus.src1_i  = '0;
      bus.src2_i  = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst:busy", 32'(bus.busy_o), 32'h0);
      check("rst:valid", 32'(bus.res_valid_o), 32'h0);
      check("rst:res", bus.res_o, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // First op is accepted on the first rising edge after release.
      run_op(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 2,  "mul7");
      run_op(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 2,  "mulh_m1");
      run_op(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 2,  "mulhsu_m1");
      run_op(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 2,  "mulhu_m1");
      run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 2,  "mulh_min");
      run_op(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, "div_m7");
      run_op(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, "rem_m7");
      run_op(OP_DIVU,   32'd100,        32'd7,         32'd14,        33, "divu100");
      run_op(OP_REMU,   32'd100,        32'd7,         32'd2,         33, "remu100");
      run_op(OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "divu_z");
      run_op(OP_REMU,   32'd5,          32'd0,         32'd5,         1,  "remu_z");
      run_op(OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "div_z");
      run_op(OP_REM,    32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 1,  "rem_z");
      run_op(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
      run_op(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1,  "rem_ovf");
      run_op(OP_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         33, "divu_noovf");

      // Flush at cycle 10 of a divide, then a fresh op on the next cycle.
      bus.op_i = OP_DIV; bus.src1_i = 32'd1000; bus.src2_i = 32'd3; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
      check("flush_div:pre_valid", 32'(bus.res_valid_o), 32'h0);
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      check("flush_div:busy", 32'(bus.busy_o), 32'h0);
      check("flush_div:valid", 32'(bus.res_valid_o), 32'h0);
      check("flush_div:res", bus.res_o, last_res);
      run_op(OP_DIVU, 32'd1000, 32'd3, 32'd333, 33, "post_flush");

      // Flush during MUL.
      bus.op_i = OP_MUL; bus.src1_i = 32'd9; bus.src2_i = 32'd9; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      check("flush_mul:busy", 32'(bus.busy_o), 32'h0);
      check("flush_mul:valid", 32'(bus.res_valid_o), 32'h0);
      check("flush_mul:res", bus.res_o, last_res);

      // Flush and start together in IDLE: no acceptance.
      bus.op_i = OP_MUL; bus.start_i = 1'b1; bus.flush_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0; bus.flush_i = 1'b0;
      check("flush_start:busy", 32'(bus.busy_o), 32'h0);
      @(posedge clk); #1;
      check("flush_start:valid", 32'(bus.res_valid_o), 32'h0);

      // Asynchronous reset in the middle of a divide.
      bus.op_i = OP_DIV; bus.src1_i = 32'hDEAD_BEEF; bus.src2_i = 32'd13; bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst:busy", 32'(bus.busy_o), 32'h0);
      check("mid_rst:valid", 32'(bus.res_valid_o), 32'h0);
      check("mid_rst:res", bus.res_o, 32'h0);
      last_res = '0;
      @(negedge clk);
      rst_n = 1'b1;
      run_op(OP_MUL, 32'd3, 32'd4, 32'd12, 2, "post_rst");

      for (int n = 0; n < 200; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         run_op(op, a, b, ref_result(op, a, b), ref_latency(op, a, b), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
